// File: rtl/dual_seq_pkg.sv
// -----------------------------------------------------------------------------
// dual_seq_pkg
// Constants and types shared by the dual sequence generator and its companion
// detector: the two framing patterns, the pattern width, the inter-repetition
// gap length and the generator FSM state encoding.
// Optional feature macro: DUAL_SEQ_GEN_GAP_EN (adds the GAP state).
// -----------------------------------------------------------------------------
package dual_seq_pkg;

    localparam int PAT_W = 4;
    localparam int IDX_W = $clog2(PAT_W);

    localparam logic [PAT_W-1:0] PAT_A = 4'b1101;
    localparam logic [PAT_W-1:0] PAT_B = 4'b1001;

    // Zero bits inserted between repetitions when the gap feature is built in.
    localparam logic [3:0] GAP_LEN = 4'd2;

`ifdef DUAL_SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1
    } state_e;
`endif

    // Map the request select bit onto the pattern it names.
    function automatic logic [PAT_W-1:0] select_pattern(input logic sel);
        logic [PAT_W-1:0] pat;
        if (sel) begin
            pat = PAT_B;
        end else begin
            pat = PAT_A;
        end
        return pat;
    endfunction

endpackage

// File: rtl/seq_bit_shifter.sv
// -----------------------------------------------------------------------------
// seq_bit_shifter
// Loadable pattern register with a down-counting bit index (MSB first).
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : latch 'pattern' and point the index at the MSB
//   pattern        : pattern to latch on 'load'
//   restart        : point the index back at the MSB, keep the pattern
//   advance        : step the index down by one
//   bit_out        : pattern bit at the current index
//   first_bit      : index is at the MSB
//   last_bit       : index is at the LSB
// -----------------------------------------------------------------------------
module seq_bit_shifter
    import dual_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             restart,
    input  logic             advance,
    output logic             bit_out,
    output logic             first_bit,
    output logic             last_bit
);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next pattern/index: load has priority over restart, restart over advance.
    always_comb begin
        pat_d = pat_q;
        idx_d = idx_q;
        if (load) begin
            pat_d = pattern;
            idx_d = IDX_MSB;
        end else if (restart) begin
            idx_d = IDX_MSB;
        end else if (advance) begin
            idx_d = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_d = idx_q;
        end
    end

    // Pattern and index registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= {PAT_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            pat_q <= pat_d;
            idx_q <= idx_d;
        end
    end

    assign bit_out   = pat_q[idx_q];
    assign first_bit = (idx_q == IDX_MSB);
    assign last_bit  = (idx_q == {IDX_W{1'b0}});

endmodule

// File: rtl/dual_seq_gen.sv
// -----------------------------------------------------------------------------
// dual_seq_gen
// Serial generator for the framing patterns 1101 / 1001, MSB first, one bit
// per clock, repeated req_count+1 times per accepted request.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req_valid      : request present
//   req_sel        : 0 selects PAT_A (1101), 1 selects PAT_B (1001)
//   req_count      : repetitions minus one
//   req_ready      : generator idle and able to accept
//   out, out_valid : serial bit and its qualifier (gap bits are valid zeros)
//   frame_start    : first bit of each repetition
//   done           : final bit of the final repetition
// Optional feature macro: DUAL_SEQ_GEN_GAP_EN inserts GAP_LEN zero bits
// between repetitions (never after the last one).
// -----------------------------------------------------------------------------
module dual_seq_gen
    import dual_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic       req_sel,
    input  logic [3:0] req_count,
    output logic       req_ready,
    output logic       out,
    output logic       out_valid,
    output logic       frame_start,
    output logic       done
);

    state_e     state_q, state_d;
    logic [3:0] rep_q, rep_d;
`ifdef DUAL_SEQ_GEN_GAP_EN
    logic [3:0] gap_q, gap_d;
`endif

    logic sh_load, sh_restart, sh_advance;
    logic sh_bit, sh_first, sh_last;

    seq_bit_shifter u_shifter (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (sh_load),
        .pattern   (select_pattern(req_sel)),
        .restart   (sh_restart),
        .advance   (sh_advance),
        .bit_out   (sh_bit),
        .first_bit (sh_first),
        .last_bit  (sh_last)
    );

    // Next-state logic and output decode from the registered state.
    always_comb begin
        state_d     = state_q;
        rep_d       = rep_q;
`ifdef DUAL_SEQ_GEN_GAP_EN
        gap_d       = gap_q;
`endif
        sh_load     = 1'b0;
        sh_restart  = 1'b0;
        sh_advance  = 1'b0;
        req_ready   = 1'b0;
        out         = 1'b0;
        out_valid   = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sh_load = 1'b1;
                    rep_d   = req_count;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                out         = sh_bit;
                out_valid   = 1'b1;
                frame_start = sh_first;
                if (sh_last) begin
                    // rep_q counts repetitions still to go after this one.
                    if (rep_q != 4'd0) begin
                        rep_d = rep_q - 4'd1;
`ifdef DUAL_SEQ_GEN_GAP_EN
                        gap_d   = GAP_LEN - 4'd1;
                        state_d = ST_GAP;
`else
                        sh_restart = 1'b1;
`endif
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sh_advance = 1'b1;
                end
            end
`ifdef DUAL_SEQ_GEN_GAP_EN
            ST_GAP: begin
                out_valid = 1'b1;
                if (gap_q == 4'd0) begin
                    sh_restart = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, repetition and gap registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rep_q   <= 4'd0;
`ifdef DUAL_SEQ_GEN_GAP_EN
            gap_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
`ifdef DUAL_SEQ_GEN_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_dual_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_dual_seq_gen
// Self-checking bench for dual_seq_gen: table-driven bursts with hand-written
// expected bit strings, held-valid back-to-back bursts, reset mid-burst, and
// randomized requests checked against a pattern/repetition reference model.
// -----------------------------------------------------------------------------
module tb_dual_seq_gen;

`ifdef DUAL_SEQ_GEN_GAP_EN
    localparam int TB_GAP = 2;
`else
    localparam int TB_GAP = 0;
`endif

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_sel;
    logic [3:0] req_count;
    logic       req_ready;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic e_out[$];
    logic e_fs[$];
    logic e_done[$];

    typedef struct {
        logic        sel;
        logic [3:0]  count;
        logic [31:0] bits;
        logic [31:0] fs_mask;
        int          len;
    } vec_t;

    vec_t tbl[3];

    dual_seq_gen dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_count   (req_count),
        .req_ready   (req_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".req_ready"},   req_ready,   1'b1);
        chk({tag, ".out_valid"},   out_valid,   1'b0);
        chk({tag, ".out"},         out,         1'b0);
        chk({tag, ".frame_start"}, frame_start, 1'b0);
        chk({tag, ".done"},        done,        1'b0);
    endtask

    // Reference model: a burst is count+1 copies of the pattern, MSB first,
    // with TB_GAP zero bits between copies and none after the last.
    task automatic build_model(input logic sel, input int cnt);
        logic [3:0] pat;
        e_out.delete(); e_fs.delete(); e_done.delete();
        pat = sel ? 4'b1001 : 4'b1101;
        for (int r = 0; r <= cnt; r++) begin
            for (int b = 3; b >= 0; b--) begin
                e_out.push_back(pat[b]);
                e_fs.push_back(b == 3);
                e_done.push_back((r == cnt) && (b == 0));
            end
            if (r < cnt) begin
                for (int g = 0; g < TB_GAP; g++) begin
                    e_out.push_back(1'b0);
                    e_fs.push_back(1'b0);
                    e_done.push_back(1'b0);
                end
            end
        end
    endtask

    // Called at a sampling point with the request already driven; the first
    // edge inside accepts it. Ends at the sampling point of the idle cycle.
    task automatic expect_burst(input logic hold, input string tag);
        int n;
        n = e_out.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (i == 0) req_valid = hold;
            chk($sformatf("%s.c%0d.out", tag, i),         out,         e_out[i]);
            chk($sformatf("%s.c%0d.out_valid", tag, i),   out_valid,   1'b1);
            chk($sformatf("%s.c%0d.frame_start", tag, i), frame_start, e_fs[i]);
            chk($sformatf("%s.c%0d.done", tag, i),        done,        e_done[i]);
            chk($sformatf("%s.c%0d.req_ready", tag, i),   req_ready,   1'b0);
            if (i == 1) begin
                // Mid-burst input changes must have no effect.
                req_sel   = ~req_sel;
                req_count = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clock); #1;
        check_idle({tag, ".idle"});
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        req_count = 4'd0;

`ifdef DUAL_SEQ_GEN_GAP_EN
        tbl[0] = '{1'b0, 4'd0, 32'b1101,               32'b1000,               4};
        tbl[1] = '{1'b1, 4'd2, 32'b1001_00_1001_00_1001, 32'b1000_00_1000_00_1000, 16};
        tbl[2] = '{1'b0, 4'd1, 32'b1101_00_1101,         32'b1000_00_1000,         10};
`else
        tbl[0] = '{1'b0, 4'd0, 32'b1101,           32'b1000,           4};
        tbl[1] = '{1'b1, 4'd2, 32'b1001_1001_1001, 32'b1000_1000_1000, 12};
        tbl[2] = '{1'b0, 4'd1, 32'b1101_1101,      32'b1000_1000,      8};
`endif

        // Reset held, then released with no request.
        repeat (2) @(posedge clock);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_idle($sformatf("no_req%0d", i));
        end

        // Table-driven bursts with explicit expected bit strings.
        for (int t = 0; t < 3; t++) begin
            e_out.delete(); e_fs.delete(); e_done.delete();
            for (int i = 0; i < tbl[t].len; i++) begin
                e_out.push_back(tbl[t].bits[tbl[t].len - 1 - i]);
                e_fs.push_back(tbl[t].fs_mask[tbl[t].len - 1 - i]);
                e_done.push_back(i == tbl[t].len - 1);
            end
            req_valid = 1'b1;
            req_sel   = tbl[t].sel;
            req_count = tbl[t].count;
            expect_burst(1'b0, $sformatf("tbl%0d", t));
        end

        // req_valid held high: bursts separated by exactly one idle cycle.
        req_valid = 1'b1;
        req_sel   = 1'b0;
        req_count = 4'd1;
        build_model(1'b0, 1);
        expect_burst(1'b1, "hold0");
        req_sel   = 1'b1;
        req_count = 4'd0;
        build_model(1'b1, 0);
        expect_burst(1'b1, "hold1");
        req_sel   = 1'b0;
        req_count = 4'd2;
        build_model(1'b0, 2);
        expect_burst(1'b0, "hold2");

        // Reset asserted on the second bit of a 16-repetition burst.
        req_valid = 1'b1;
        req_sel   = 1'b0;
        req_count = 4'd15;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rst_mid.bit1.out", out, 1'b1);
        chk("rst_mid.bit1.frame_start", frame_start, 1'b1);
        @(posedge clock); #1;
        chk("rst_mid.bit2.out", out, 1'b1);
        chk("rst_mid.bit2.frame_start", frame_start, 1'b0);
        reset_n = 1'b0;
        #1;
        check_idle("rst_mid.async");
        @(posedge clock); #1;
        check_idle("rst_mid.held");
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_idle("rst_mid.released");
        req_valid = 1'b1;
        req_sel   = 1'b1;
        req_count = 4'd0;
        build_model(1'b1, 0);
        expect_burst(1'b0, "after_rst");

        // Randomized requests against the reference model.
        for (int k = 0; k < 12; k++) begin
            logic s;
            int   c;
            s = 1'($urandom_range(0, 1));
            c = $urandom_range(0, 4);
            build_model(s, c);
            req_valid = 1'b1;
            req_sel   = s;
            req_count = 4'(c);
            expect_burst(1'b0, $sformatf("rnd%0d", k));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                @(posedge clock); #1;
                check_idle($sformatf("rnd%0d.quiet%0d", k, j));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
